imem_loader: RTL and testbench



---
 rtl/imem_loader_pkg.sv | 30 +++
 rtl/imem_word_assembler.sv | 39 +++
 rtl/imem_loader.sv | 119 +++++++++++
 tb/tb_imem_loader.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared constants, state encoding and helpers for the instruction-memory boot loader.
// Frame field order: LEN_LO, LEN_HI, 4*N payload bytes (little-endian words), CSUM.
package imem_loader_pkg;

  localparam int INSTR_BUS_BITS = 32;
  localparam int IMEM_DEPTH     = 256;
  localparam int IMEM_ADDR_BITS = 8;
  localparam int LEN_BITS       = 16;

  typedef enum logic [2:0] {
    IMEM_LDR_IDLE   = 3'd0,
    IMEM_LDR_LEN_LO = 3'd1,
    IMEM_LDR_LEN_HI = 3'd2,
    IMEM_LDR_DATA   = 3'd3,
    IMEM_LDR_CSUM   = 3'd4,
    IMEM_LDR_DONE   = 3'd5,
    IMEM_LDR_ERROR  = 3'd6
  } imem_ldr_state_e;

  // States in which a frame is being received; these also accept bytes.
  function automatic logic is_frame_state(input imem_ldr_state_e s);
    return (s == IMEM_LDR_LEN_LO) || (s == IMEM_LDR_LEN_HI) ||
           (s == IMEM_LDR_DATA)   || (s == IMEM_LDR_CSUM);
  endfunction

  function automatic logic is_idle_state(input imem_ldr_state_e s);
    return (s == IMEM_LDR_IDLE) || (s == IMEM_LDR_DONE) || (s == IMEM_LDR_ERROR);
  endfunction

endpackage

// File: rtl/imem_word_assembler.sv
// Collects payload bytes into little-endian 32-bit words and keeps the running XOR checksum.
module imem_word_assembler
  import imem_loader_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      byte_en,
  input  logic [7:0]                byte_data,
  output logic                      word_valid,
  output logic [INSTR_BUS_BITS-1:0] word,
  output logic [7:0]                csum
);

  // Holds the first three bytes of the current word; byte 0 ends up in the low lane.
  logic [INSTR_BUS_BITS-9:0] shift_q;
  logic [1:0]                byte_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q  <= '0;
      byte_idx <= '0;
      csum     <= '0;
    end else if (clr) begin
      shift_q  <= '0;
      byte_idx <= '0;
      csum     <= '0;
    end else if (byte_en) begin
      shift_q  <= {byte_data, shift_q[INSTR_BUS_BITS-9:8]};
      byte_idx <= byte_idx + 2'd1;
      csum     <= csum ^ byte_data;
    end
  end

  // The fourth byte completes the word combinationally so the write can be registered next edge.
  assign word_valid = byte_en && (byte_idx == 2'd3);
  assign word       = {byte_data, shift_q};

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: parses a framed byte stream and writes instruction words into imem,
// holding the core in reset until a full frame with a valid checksum has landed.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int ADDR_W = IMEM_ADDR_BITS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      in_valid,
  input  logic [7:0]                in_data,
  output logic                      in_ready,
  output logic                      we,
  output logic [ADDR_W-1:0]         waddr,
  output logic [INSTR_BUS_BITS-1:0] wdata,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic                      core_rst_n
);

  localparam logic [LEN_BITS:0] DEPTH_L = (LEN_BITS+1)'(DEPTH);

  imem_ldr_state_e state, state_nxt;

  logic [7:0]                len_lo;
  logic [LEN_BITS-1:0]       len;
  logic [LEN_BITS-1:0]       len_rx;
  logic [ADDR_W-1:0]         widx;
  logic                      accept;
  logic                      arm;
  logic                      last_word;
  logic                      word_valid;
  logic [INSTR_BUS_BITS-1:0] word;
  logic [7:0]                csum;

  assign in_ready  = is_frame_state(state);
  assign accept    = in_valid && in_ready;
  assign arm       = start && is_idle_state(state);
  assign len_rx    = {in_data, len_lo};
  assign last_word = (LEN_BITS'(widx) == (len - LEN_BITS'(1)));

  imem_word_assembler u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (arm),
    .byte_en    (accept && (state == IMEM_LDR_DATA)),
    .byte_data  (in_data),
    .word_valid (word_valid),
    .word       (word),
    .csum       (csum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IMEM_LDR_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IMEM_LDR_IDLE, IMEM_LDR_DONE, IMEM_LDR_ERROR: begin
        if (start) state_nxt = IMEM_LDR_LEN_LO;
      end
      IMEM_LDR_LEN_LO: begin
        if (accept) state_nxt = IMEM_LDR_LEN_HI;
      end
      IMEM_LDR_LEN_HI: begin
        // Oversized frames are rejected here so the word index can never reach DEPTH.
        if (accept) begin
          if ({1'b0, len_rx} > DEPTH_L) state_nxt = IMEM_LDR_ERROR;
          else if (len_rx == '0)        state_nxt = IMEM_LDR_CSUM;
          else                          state_nxt = IMEM_LDR_DATA;
        end
      end
      IMEM_LDR_DATA: begin
        if (word_valid && last_word) state_nxt = IMEM_LDR_CSUM;
      end
      IMEM_LDR_CSUM: begin
        if (accept) state_nxt = (in_data == csum) ? IMEM_LDR_DONE : IMEM_LDR_ERROR;
      end
      default: state_nxt = IMEM_LDR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_lo     <= '0;
      len        <= '0;
      widx       <= '0;
      we         <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      core_rst_n <= 1'b0;
    end else begin
      we <= 1'b0;
      if (arm) widx <= '0;
      if (accept && (state == IMEM_LDR_LEN_LO)) len_lo <= in_data;
      if (accept && (state == IMEM_LDR_LEN_HI)) len    <= len_rx;
      if (word_valid) begin
        we    <= 1'b1;
        waddr <= widx;
        wdata <= word;
        if (!last_word) widx <= widx + ADDR_W'(1);
      end
      // Status flags follow the next state so they are registered yet aligned with it.
      busy       <= is_frame_state(state_nxt);
      done       <= (state_nxt == IMEM_LDR_DONE);
      err        <= (state_nxt == IMEM_LDR_ERROR);
      core_rst_n <= (state_nxt == IMEM_LDR_DONE);
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: frames are built from word lists, expected writes queued.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        we;
  logic [7:0]  waddr;
  logic [31:0] wdata;
  logic        busy, done, err, core_rst_n;

  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] frame_words[$];
  int          errors = 0;
  int          checks = 0;

  imem_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .core_rst_n (core_rst_n)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Scoreboard monitor: every write pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_we: got waddr=%h wdata=%h expected no write", waddr, wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("waddr", {24'h0, waddr}, {24'h0, e.a});
        chk("wdata", wdata, e.d);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int cnt;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        tick();
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    cnt = 0;
    @(negedge clk);
    while (!in_ready && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 expected 1");
    end
    tick();
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Reference model: frame bytes and expected writes come straight from the word list.
  task automatic load(input bit corrupt, input bit gaps, input int mid_start);
    logic [7:0] bq[$];
    logic [7:0] cs;
    int         n;
    n  = frame_words.size();
    cs = 8'h00;
    bq.push_back(8'(n));
    bq.push_back(8'(n >> 8));
    foreach (frame_words[i]) begin
      for (int k = 0; k < 4; k++) begin
        logic [7:0] b;
        b = 8'(frame_words[i] >> (8 * k));
        bq.push_back(b);
        cs ^= b;
      end
      exp_q.push_back('{a: 8'(i), d: frame_words[i]});
    end
    bq.push_back(corrupt ? (cs ^ 8'(1 << $urandom_range(0, 7))) : cs);
    pulse_start();
    chk("armed_busy", {31'h0, busy}, 32'd1);
    chk("armed_done", {31'h0, done}, 32'd0);
    chk("armed_err", {31'h0, err}, 32'd0);
    chk("armed_core_rst_n", {31'h0, core_rst_n}, 32'd0);
    foreach (bq[i]) begin
      if (i == mid_start) start = 1'b1;
      send_byte(bq[i], gaps);
      start = 1'b0;
    end
    tick();
    tick();
    chk("end_done", {31'h0, done}, {31'h0, !corrupt});
    chk("end_err", {31'h0, err}, {31'h0, corrupt});
    chk("end_core_rst_n", {31'h0, core_rst_n}, {31'h0, !corrupt});
    chk("end_busy", {31'h0, busy}, 32'd0);
    chk("writes_drained", exp_q.size(), 32'd0);
  endtask

  task automatic random_words(input int n);
    frame_words.delete();
    for (int i = 0; i < n; i++) frame_words.push_back($urandom);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_we"}, {31'h0, we}, 32'd0);
    chk({tag, "_waddr"}, {24'h0, waddr}, 32'd0);
    chk({tag, "_wdata"}, wdata, 32'd0);
    chk({tag, "_in_ready"}, {31'h0, in_ready}, 32'd0);
    chk({tag, "_busy"}, {31'h0, busy}, 32'd0);
    chk({tag, "_done"}, {31'h0, done}, 32'd0);
    chk({tag, "_err"}, {31'h0, err}, 32'd0);
    chk({tag, "_core_rst_n"}, {31'h0, core_rst_n}, 32'd0);
  endtask

  initial begin
    repeat (3) tick();
    check_reset_values("reset");
    rst_n = 1'b1;
    tick();

    // Two-word reference frame.
    frame_words = '{32'h00A00513, 32'h00B00593};
    load(1'b0, 1'b0, -1);

    // Empty frames, good and bad checksum.
    frame_words.delete();
    load(1'b0, 1'b0, -1);
    load(1'b1, 1'b0, -1);

    // Oversized length: error right after LEN_HI, nothing accepted afterwards.
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    chk("oversize_err", {31'h0, err}, 32'd1);
    chk("oversize_busy", {31'h0, busy}, 32'd0);
    chk("oversize_core_rst_n", {31'h0, core_rst_n}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      @(negedge clk);
      chk("oversize_in_ready", {31'h0, in_ready}, 32'd0);
      tick();
    end
    in_valid = 1'b0;

    // One-word frame with random in_valid gaps.
    frame_words = '{32'hDEADBEEF};
    load(1'b0, 1'b1, -1);

    // Reset mid-frame after five payload bytes.
    random_words(2);
    exp_q.push_back('{a: 8'h00, d: frame_words[0]});
    pulse_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int k = 0; k < 5; k++) begin
      int wi;
      wi = k / 4;
      send_byte(8'(frame_words[wi] >> (8 * (k % 4))), 1'b0);
    end
    rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    chk("midreset_drained", exp_q.size(), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    random_words(1);
    load(1'b0, 1'b0, -1);

    // Start pulse mid-frame is ignored; start in DONE re-arms a reload.
    random_words(3);
    load(1'b0, 1'b1, 7);
    random_words(2);
    load(1'b0, 1'b0, -1);

    // Randomized frames.
    for (int f = 0; f < 6; f++) begin
      random_words($urandom_range(1, 6));
      load(($urandom_range(0, 3) == 0), $urandom_range(0, 1), -1);
    end

    // Full-depth frame exercises the last legal word index.
    random_words(256);
    load(1'b0, 1'b0, -1);

    repeat (4) tick();
    chk("final_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
